// File: rtl/decryption_cfg_sequencer_if.sv
// Host request and register-file access signals of the decryption reconfiguration sequencer.
interface decryption_cfg_sequencer_if #(
  parameter int unsigned addr_witdth = 8,
  parameter int unsigned reg_width   = 16
);
  logic                   cfg_req;
  logic [1:0]             cfg_sel;
  logic [reg_width-1:0]   cfg_key;
  logic                   cfg_ready;
  logic                   cfg_done;
  logic [1:0]             cfg_status;

  logic [addr_witdth-1:0] reg_addr;
  logic                   reg_read;
  logic                   reg_write;
  logic [reg_width-1:0]   reg_wdata;
  logic [reg_width-1:0]   reg_rdata;
  logic                   reg_done;
  logic                   reg_error;

  // master: the sequencer (serves the host, drives the register port)
  modport master (
    input  cfg_req, cfg_sel, cfg_key, reg_rdata, reg_done, reg_error,
    output cfg_ready, cfg_done, cfg_status, reg_addr, reg_read, reg_write, reg_wdata
  );

  // slave: host plus register file seen from the outside
  modport slave (
    output cfg_req, cfg_sel, cfg_key, reg_rdata, reg_done, reg_error,
    input  cfg_ready, cfg_done, cfg_status, reg_addr, reg_read, reg_write, reg_wdata
  );
endinterface

// File: rtl/decryption_cfg_sequencer.sv
// Reconfiguration sequencer: holds the stream, waits for the engines to drain, then writes
// the selected engine key, verifies it by read-back and finally writes the select register.
module decryption_cfg_sequencer #(
  parameter int unsigned            addr_witdth  = 8,
  parameter int unsigned            reg_width    = 16,
  parameter int unsigned            DRAIN_CYCLES = 4,
  parameter int unsigned            TIMEOUT      = 15,
  parameter logic [addr_witdth-1:0] SELECT_ADDR  = addr_witdth'(8'h00),
  parameter logic [addr_witdth-1:0] CAESAR_ADDR  = addr_witdth'(8'h10),
  parameter logic [addr_witdth-1:0] SCYTALE_ADDR = addr_witdth'(8'h12),
  parameter logic [addr_witdth-1:0] ZIGZAG_ADDR  = addr_witdth'(8'h14)
) (
  input  logic                       clk_sys,
  input  logic                       rst,
  input  logic                       dp_busy,
  output logic                       stream_hold,
  decryption_cfg_sequencer_if.master bus
);

  localparam int unsigned DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam int unsigned TMO_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_CYCLES - 1);
  localparam logic [TMO_W-1:0]   TMO_LAST   = TMO_W'(TIMEOUT - 1);

  typedef enum logic [3:0] {
    IDLE,
    DRAIN,
    WR_KEY,
    WAIT_KEY,
    RD_KEY,
    WAIT_RD,
    WR_SEL,
    WAIT_SEL,
    OK,
    ERR
  } state_e;

  typedef enum logic [1:0] {
    ST_OK      = 2'b00,
    ST_BAD_SEL = 2'b01,
    ST_REG_ERR = 2'b10,
    ST_TIMEOUT = 2'b11
  } status_e;

  state_e               state_q, state_d;
  status_e              status_q, status_d;
  logic [1:0]           sel_q;
  logic [reg_width-1:0] key_q;
  logic [DRAIN_W-1:0]   drain_q, drain_d;
  logic [TMO_W-1:0]     tmo_q, tmo_d;

  logic                   access_fail;
  logic [addr_witdth-1:0] key_addr;

  logic                   ready;
  logic                   done;
  logic [1:0]             status;
  logic                   hold;
  logic [addr_witdth-1:0] addr;
  logic                   rd;
  logic                   wr;
  logic [reg_width-1:0]   wdata;

  // A completed access fails on a bus error, or on a read-back that does not match the key.
  assign access_fail = bus.reg_error || ((state_q == WAIT_RD) && (bus.reg_rdata != key_q));

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      state_q  <= IDLE;
      status_q <= ST_OK;
      sel_q    <= '0;
      key_q    <= '0;
      drain_q  <= '0;
      tmo_q    <= '0;
    end else begin
      state_q  <= state_d;
      status_q <= status_d;
      drain_q  <= drain_d;
      tmo_q    <= tmo_d;
      if ((state_q == IDLE) && bus.cfg_req) begin
        sel_q <= bus.cfg_sel;
        key_q <= bus.cfg_key;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    status_d = status_q;
    drain_d  = '0;
    tmo_d    = '0;

    unique case (sel_q)
      2'd0:    key_addr = CAESAR_ADDR;
      2'd1:    key_addr = SCYTALE_ADDR;
      2'd2:    key_addr = ZIGZAG_ADDR;
      default: key_addr = '0;
    endcase

    unique case (state_q)
      IDLE: begin
        if (bus.cfg_req) state_d = DRAIN;
      end
      DRAIN: begin
        // An invalid select is rejected before any quiet time is spent on it.
        if (sel_q == 2'd3) begin
          state_d  = ERR;
          status_d = ST_BAD_SEL;
        end else if (!dp_busy) begin
          if (drain_q == DRAIN_LAST) state_d = WR_KEY;
          else                       drain_d = drain_q + 1'b1;
        end
      end
      WR_KEY: state_d = WAIT_KEY;
      RD_KEY: state_d = WAIT_RD;
      WR_SEL: state_d = WAIT_SEL;
      WAIT_KEY, WAIT_RD, WAIT_SEL: begin
        // tmo_q is zero on entry because every non-wait state leaves it cleared.
        if (bus.reg_done) begin
          if (access_fail) begin
            state_d  = ERR;
            status_d = ST_REG_ERR;
          end else if (state_q == WAIT_KEY) begin
            state_d = RD_KEY;
          end else if (state_q == WAIT_RD) begin
            state_d = WR_SEL;
          end else begin
            state_d  = OK;
            status_d = ST_OK;
          end
        end else if (tmo_q == TMO_LAST) begin
          state_d  = ERR;
          status_d = ST_TIMEOUT;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      OK, ERR: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    ready  = (state_q == IDLE);
    hold   = (state_q != IDLE);
    done   = (state_q == OK) || (state_q == ERR);
    status = done ? status_q : ST_OK;
    wr     = (state_q == WR_KEY) || (state_q == WR_SEL);
    rd     = (state_q == RD_KEY);
    addr   = '0;
    wdata  = '0;
    if ((state_q == WR_KEY) || (state_q == RD_KEY)) addr = key_addr;
    if (state_q == WR_SEL)                          addr = SELECT_ADDR;
    if (state_q == WR_KEY)                          wdata = key_q;
    if (state_q == WR_SEL)                          wdata = reg_width'(sel_q);
  end

  assign stream_hold    = hold;
  assign bus.cfg_ready  = ready;
  assign bus.cfg_done   = done;
  assign bus.cfg_status = status;
  assign bus.reg_addr   = addr;
  assign bus.reg_read   = rd;
  assign bus.reg_write  = wr;
  assign bus.reg_wdata  = wdata;

endmodule

// File: tb/tb_decryption_cfg_sequencer.sv
// Scoreboard bench: a timeline model predicts each register access and completion per request.
module tb_decryption_cfg_sequencer;
  localparam int AW    = 8;
  localparam int RW    = 16;
  localparam int DRAIN = 4;
  localparam int TMO   = 15;
  localparam int LIMIT = 150;

  typedef enum int {EV_WR, EV_RD, EV_DONE} ev_kind_e;
  typedef struct {
    ev_kind_e    kind;
    logic [7:0]  addr;
    logic [15:0] data;
    int          at;
  } ev_t;

  logic clk_sys = 1'b0;
  logic rst     = 1'b1;
  logic dp_busy = 1'b0;
  logic stream_hold;

  decryption_cfg_sequencer_if #(.addr_witdth(AW), .reg_width(RW)) bus ();

  decryption_cfg_sequencer #(
    .addr_witdth (AW),
    .reg_width   (RW),
    .DRAIN_CYCLES(DRAIN),
    .TIMEOUT     (TMO)
  ) dut (
    .clk_sys    (clk_sys),
    .rst        (rst),
    .dp_busy    (dp_busy),
    .stream_hold(stream_hold),
    .bus        (bus)
  );

  always #5 clk_sys = ~clk_sys;

  int cyc = 0;
  always @(posedge clk_sys) cyc <= cyc + 1;

  ev_t exp_q[$];
  int  n_checks = 0;
  int  n_fail   = 0;

  // Register-file scenario for the current request (latency 0 = never answers)
  int          lat_wk, lat_rd, lat_ws;
  bit          err_wk, err_rd, err_ws;
  logic [15:0] corrupt_mask;
  bit          busy_q[$];
  int          drain_k;

  logic [15:0] mem [256];
  bit          pend = 1'b0;
  int          pend_at = 0;
  bit          pend_err = 1'b0;
  logic [15:0] pend_data = '0;

  function automatic void push(ev_kind_e k, logic [7:0] ad, logic [15:0] d, int at);
    ev_t e;
    e.kind = k;
    e.addr = ad;
    e.data = d;
    e.at   = at;
    exp_q.push_back(e);
  endfunction

  function automatic bit busy_at(int k);
    if (k >= 1 && k <= busy_q.size()) return busy_q[k-1];
    return 1'b0;
  endfunction

  // Resolves one access started at strobe cycle s; returns 1 when it ends the request.
  function automatic bit finish_access(input int s, input int lat, input bit fail, output int next_at);
    if (lat == 0) begin
      next_at = s + 1 + TMO;
      push(EV_DONE, 8'h00, 16'h0003, next_at);
      return 1'b1;
    end
    next_at = s + lat + 1;
    if (fail) begin
      push(EV_DONE, 8'h00, 16'h0002, next_at);
      return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic predict(input int a, input logic [1:0] sel, input logic [15:0] key, output int done_at);
    int run, k, t1, t2, t3, t4;
    logic [7:0] ka;
    if (sel == 2'd3) begin
      drain_k = 1;
      done_at = a + 2;
      push(EV_DONE, 8'h00, 16'h0001, done_at);
      return;
    end
    run = 0;
    k   = 0;
    while (run < DRAIN) begin
      k++;
      run = busy_at(k) ? 0 : run + 1;
    end
    drain_k = k;
    ka = 8'h10 + 8'(2 * int'(sel));
    t1 = a + k + 1;
    push(EV_WR, ka, key, t1);
    if (finish_access(t1, lat_wk, err_wk, t2)) begin done_at = t2; return; end
    push(EV_RD, ka, 16'h0000, t2);
    if (finish_access(t2, lat_rd, err_rd || (corrupt_mask != 16'h0000), t3)) begin done_at = t3; return; end
    push(EV_WR, 8'h00, 16'(sel), t3);
    if (finish_access(t3, lat_ws, err_ws, t4)) begin done_at = t4; return; end
    push(EV_DONE, 8'h00, 16'h0000, t4);
    done_at = t4;
  endtask

  task automatic set_scn(input int lwk, input int lrd, input int lws,
                         input bit ewk, input bit erd, input bit ews, input logic [15:0] mask);
    lat_wk = lwk; lat_rd = lrd; lat_ws = lws;
    err_wk = ewk; err_rd = erd; err_ws = ews;
    corrupt_mask = mask;
  endtask

  task automatic check_reset(input string tag);
    n_checks++;
    if (!(bus.cfg_ready === 1'b1 && bus.cfg_done === 1'b0 && bus.cfg_status === 2'b00 &&
          stream_hold === 1'b0 && bus.reg_read === 1'b0 && bus.reg_write === 1'b0 &&
          bus.reg_addr === 8'h00 && bus.reg_wdata === 16'h0000)) begin
      n_fail++;
      $display("FAIL %s: ready=%b done=%b status=%b hold=%b rd=%b wr=%b addr=%h wdata=%h, required ready=1 and all others 0",
               tag, bus.cfg_ready, bus.cfg_done, bus.cfg_status, stream_hold,
               bus.reg_read, bus.reg_write, bus.reg_addr, bus.reg_wdata);
    end
  endtask

  // Issues one request; rst_at>0 pulses reset in cycle accept+rst_at instead of waiting for completion.
  task automatic run_req(input logic [1:0] sel, input logic [15:0] key, input int rst_at);
    int a, done_at;
    bit seen;
    @(posedge clk_sys); #1;
    bus.cfg_req = 1'b1;
    bus.cfg_sel = sel;
    bus.cfg_key = key;
    dp_busy     = 1'b0;
    a = cyc;
    predict(a, sel, key, done_at);
    seen = 1'b0;
    for (int k = 1; k <= LIMIT && !seen; k++) begin
      @(posedge clk_sys); #1;
      bus.cfg_req = (k == 1);
      bus.cfg_sel = 2'($urandom);
      bus.cfg_key = 16'($urandom);
      dp_busy = (k <= drain_k) ? busy_at(k) : 1'($urandom_range(0, 1));
      rst = (rst_at != 0) && (k == rst_at);
      @(negedge clk_sys);
      if (rst_at != 0 && k == rst_at + 1) begin
        check_reset("reset_mid_sequence");
        for (int i = exp_q.size() - 1; i >= 0; i--)
          if (exp_q[i].at >= a + rst_at) exp_q.delete(i);
        seen = 1'b1;
      end else if (rst_at == 0 && bus.cfg_ready) begin
        seen = 1'b1;
        n_checks++;
        if (cyc != done_at + 1) begin
          n_fail++;
          $display("FAIL ready_return: cfg_ready back at cycle %0d, required %0d (accept %0d)", cyc, done_at + 1, a);
        end
      end
    end
    if (!seen) begin
      n_checks++;
      n_fail++;
      $display("FAIL request_timeout: no completion within %0d cycles of accept at %0d", LIMIT, a);
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL missing_events: %0d expected events not seen, required 0 (next at cycle %0d)",
               exp_q.size(), exp_q[0].at);
      exp_q.delete();
    end
    bus.cfg_req = 1'b0;
    dp_busy     = 1'b0;
  endtask

  // Monitor: bus rules every cycle, scoreboard pop on each DUT output, register-file responder.
  always @(negedge clk_sys) begin : mon
    ev_t         e;
    ev_kind_e    gk;
    logic [15:0] gd;
    if (rst) begin
      pend = 1'b0;
    end else begin
      n_checks++;
      if ((bus.reg_read && bus.reg_write) ||
          (!bus.reg_read && !bus.reg_write && (bus.reg_addr != 8'h00 || bus.reg_wdata != 16'h0000)) ||
          (stream_hold == bus.cfg_ready)) begin
        n_fail++;
        $display("FAIL bus_rules: cyc=%0d rd=%b wr=%b addr=%h wdata=%h hold=%b ready=%b, required one strobe max, zero addr/wdata without strobe, hold = !ready",
                 cyc, bus.reg_read, bus.reg_write, bus.reg_addr, bus.reg_wdata, stream_hold, bus.cfg_ready);
      end
      if (bus.reg_write || bus.reg_read || bus.cfg_done) begin
        gk = bus.reg_write ? EV_WR : (bus.reg_read ? EV_RD : EV_DONE);
        gd = (bus.reg_write || bus.reg_read) ? bus.reg_wdata : 16'(bus.cfg_status);
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_output: cyc=%0d kind=%0d addr=%h data=%h, required no output", cyc, int'(gk), bus.reg_addr, gd);
        end else begin
          e = exp_q.pop_front();
          if (gk != e.kind || bus.reg_addr != e.addr || gd != e.data || cyc != e.at) begin
            n_fail++;
            $display("FAIL scoreboard: got kind=%0d addr=%h data=%h cyc=%0d, required kind=%0d addr=%h data=%h cyc=%0d",
                     int'(gk), bus.reg_addr, gd, cyc, int'(e.kind), e.addr, e.data, e.at);
          end
        end
      end
      if (bus.reg_write || bus.reg_read) begin
        int lat;
        if (bus.reg_read) begin
          lat       = lat_rd;
          pend_err  = err_rd;
          pend_data = mem[bus.reg_addr] ^ corrupt_mask;
        end else begin
          lat       = (bus.reg_addr == 8'h00) ? lat_ws : lat_wk;
          pend_err  = (bus.reg_addr == 8'h00) ? err_ws : err_wk;
          pend_data = '0;
          mem[bus.reg_addr] = bus.reg_wdata;
        end
        pend    = (lat != 0);
        pend_at = cyc + lat;
      end
    end
  end

  initial begin
    bus.reg_done  = 1'b0;
    bus.reg_error = 1'b0;
    bus.reg_rdata = '0;
    forever begin
      @(posedge clk_sys); #1;
      bus.reg_done  = pend && (cyc == pend_at);
      bus.reg_error = bus.reg_done && pend_err;
      bus.reg_rdata = bus.reg_done ? pend_data : 16'($urandom);
    end
  end

  initial begin
    logic [1:0]  sel;
    logic [15:0] key;
    int          mode;
    for (int i = 0; i < 256; i++) mem[i] = '0;
    bus.cfg_req = 1'b0;
    bus.cfg_sel = '0;
    bus.cfg_key = '0;
    set_scn(1, 1, 1, 1'b0, 1'b0, 1'b0, 16'h0000);
    rst = 1'b1;
    repeat (3) @(posedge clk_sys);
    @(negedge clk_sys);
    check_reset("reset_state");
    @(posedge clk_sys); #1;
    rst = 1'b0;

    // Idle datapath, caesar: write +5, read +7, select +9, done +11
    busy_q.delete();
    run_req(2'd0, 16'h0003, 0);
    // Scytale with datapath busy for cycles 1..6
    busy_q = '{1, 1, 1, 1, 1, 1};
    set_scn(1, 1, 1, 1'b0, 1'b0, 1'b0, 16'h0000);
    run_req(2'd1, 16'hBEEF, 0);
    // Invalid select
    busy_q.delete();
    run_req(2'd3, 16'h1234, 0);
    // Zigzag read-back returns 0 for written 5
    set_scn(1, 1, 1, 1'b0, 1'b0, 1'b0, 16'h0005);
    run_req(2'd2, 16'h0005, 0);
    // No reg_done after key write
    set_scn(0, 1, 1, 1'b0, 1'b0, 1'b0, 16'h0000);
    run_req(2'd0, 16'h00A5, 0);
    // Reset while waiting for read data, then a clean request
    set_scn(1, 3, 1, 1'b0, 1'b0, 1'b0, 16'h0000);
    run_req(2'd1, 16'h5A5A, 8);
    set_scn(1, 1, 1, 1'b0, 1'b0, 1'b0, 16'h0000);
    run_req(2'd2, 16'hC001, 0);

    for (int n = 0; n < 40; n++) begin
      sel = (($urandom_range(0, 7)) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      key = 16'($urandom);
      busy_q.delete();
      for (int b = 0; b < int'($urandom_range(0, 10)); b++) busy_q.push_back(1'($urandom_range(0, 1)));
      set_scn($urandom_range(1, 3), $urandom_range(1, 3), $urandom_range(1, 3),
              1'b0, 1'b0, 1'b0, 16'h0000);
      mode = $urandom_range(0, 11);
      case (mode)
        0: lat_wk = 0;
        1: lat_rd = 0;
        2: lat_ws = 0;
        3: err_wk = 1'b1;
        4: err_rd = 1'b1;
        5: err_ws = 1'b1;
        6: corrupt_mask = 16'($urandom_range(1, 16'hFFFF));
        default: ;
      endcase
      repeat ($urandom_range(0, 2)) @(posedge clk_sys);
      run_req(sel, key, 0);
    end

    repeat (3) @(negedge clk_sys);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL final_queue: %0d expected events left, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
